multicycle_control: RTL and testbench

Multi-cycle control FSM for the RV32I core subset. It sequences fetch, decode, execute, memory and writeback for a shared-ALU, shared-memory datapath. Each cycle it drives ImmSrc to the sign-extend unit (Imm=0, Store=1, Branch=2, Jump=3, UppImm=4), along with all datapath mux selects and write enables. It handshakes with memory through MemReq/MemReady.

---
 rtl/multicycle_control.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for an RV32I subset on a shared-ALU, shared-memory
// datapath. Sequences fetch/decode/execute/memory/writeback and drives every
// datapath select and write enable combinationally from the current state.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (forces all outputs to 0)
//   instr        instruction register contents (op, funct3, funct7b5 decoded)
//   Zero         ALU zero flag, same cycle
//   MemReady     memory completes the current request this cycle
//   MemReq       memory access request
//   MemWrite     store qualifier, meaningful only with MemReq
//   AdrSrc       memory address select: 0=PC, 1=ALUOut
//   IRWrite      load IR and OldPC
//   PCWrite      load PC from the Result bus
//   RegWrite     register file write
//   ImmSrc       immediate format: Imm=0, Store=1, Branch=2, Jump=3, UppImm=4
//   ALUSrcA      00=PC, 01=OldPC, 10=RD1, 11=zero
//   ALUSrcB      00=RD2, 01=ImmExt, 10=const 4
//   ALUControl   000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   ResultSrc    00=ALUOut, 01=memory data, 10=ALU result direct
//   IllegalInstr high while trapped on an unsupported instruction
module multicycle_control #(
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   MemReq,
  output logic                   MemWrite,
  output logic                   AdrSrc,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   RegWrite,
  output logic [2:0]             ImmSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ALUControl,
  output logic [1:0]             ResultSrc,
  output logic                   IllegalInstr
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  // funct3 values
  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;
  localparam logic [F3_W-1:0] F3_WORD = 3'b010;
  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OP_W-1:0] op;
  logic [F3_W-1:0] funct3;
  logic            funct7b5;
  logic [2:0]      alu_op_c;
  logic            alu_f3_ok_c;
  logic            unused_instr;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  // Only a few IR fields steer control; the rest feed the datapath.
  assign unused_instr = ^instr;

  // funct3 -> ALU op for R/I-type; sub only for R-type with funct7b5 set.
  always_comb begin
    alu_op_c    = ALU_ADD;
    alu_f3_ok_c = 1'b1;
    unique case (funct3)
      F3_ADD:  alu_op_c = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      F3_SLT:  alu_op_c = ALU_SLT;
      F3_XOR:  alu_op_c = ALU_XOR;
      F3_OR:   alu_op_c = ALU_OR;
      F3_AND:  alu_op_c = ALU_AND;
      default: alu_f3_ok_c = 1'b0;  // shifts and sltu are not supported
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_d      = state_q;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ImmSrc       = IMM_I;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    ALUControl   = ALU_ADD;
    ResultSrc    = RES_ALUOUT;
    IllegalInstr = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        MemReq = 1'b1;
        AdrSrc = 1'b0;
        if (MemReady) begin
          // Latch IR/OldPC and advance PC to PC+4 in the same cycle.
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          ALUSrcA    = SRCA_PC;
          ALUSrcB    = SRCB_FOUR;
          ALUControl = ALU_ADD;
          ResultSrc  = RES_ALU;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        // Precompute OldPC+imm; JAL reuses it as the jump target.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        ImmSrc     = (op == OP_JAL) ? IMM_J : IMM_B;
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:  state_d = alu_f3_ok_c ? S_EXECR : S_TRAP;
          OP_ITYPE:  state_d = alu_f3_ok_c ? S_EXECI : S_TRAP;
          OP_BRANCH: state_d = (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_BRANCH : S_TRAP;
          OP_JAL:    state_d = S_JAL;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        // AdrSrc preset so the address is already ALUOut when the access starts.
        AdrSrc     = 1'b1;
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
        if (funct3 != F3_WORD) begin
          state_d = S_TRAP;
        end else if (op == OP_STORE) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end

      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) begin
          state_d = S_FETCH;
        end
      end

      S_EXECR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUControl = alu_op_c;
        state_d    = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        ALUControl = alu_op_c;
        state_d    = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        // Compare via subtraction; ALUOut still holds the target from DECODE.
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_SUB;
        ResultSrc  = RES_ALUOUT;
        PCWrite    = (funct3 == F3_BNE) ? ~Zero : Zero;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        // Redirect PC to ALUOut while computing the link value OldPC+4.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        PCWrite    = 1'b1;
        state_d    = S_ALUWB;
      end

      S_LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_U;
        ALUControl = ALU_ADD;
        state_d    = S_ALUWB;
      end

      S_TRAP: begin
        IllegalInstr = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset quiets every control line, including mid-access.
    if (rst) begin
      MemReq       = 1'b0;
      MemWrite     = 1'b0;
      AdrSrc       = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegWrite     = 1'b0;
      ImmSrc       = IMM_I;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_RD2;
      ALUControl   = ALU_ADD;
      ResultSrc    = RES_ALUOUT;
      IllegalInstr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. Every control output
// is packed into one vector and compared against hand-built expected vectors.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
  logic        MemReady;
  logic        MemReq;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [2:0]  ImmSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic        IllegalInstr;

  logic [18:0] ctrl;

  int checks    = 0;
  int failures  = 0;
  int irw_count = 0;

  multicycle_control #(.INSTR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .Zero         (Zero),
    .MemReady     (MemReady),
    .MemReq       (MemReq),
    .MemWrite     (MemWrite),
    .AdrSrc       (AdrSrc),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .RegWrite     (RegWrite),
    .ImmSrc       (ImmSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUControl   (ALUControl),
    .ResultSrc    (ResultSrc),
    .IllegalInstr (IllegalInstr)
  );

  assign ctrl = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, IllegalInstr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Build an expected control vector in the same order as ctrl.
  function automatic logic [18:0] cv(input logic mreq, input logic mw, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [2:0] imm, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] rs, input logic ill);
    return {mreq, mw, adr, irw, pcw, rw, imm, sa, sb, alu, rs, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; samples at negedge, returns at next posedge+1.
  task automatic run_cycle(input string tag, input logic [18:0] exp);
    @(negedge clk);
    if (IRWrite === 1'b1) irw_count++;
    check(tag, 32'(ctrl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  localparam logic [18:0] C_ZERO       = 19'd0;
  localparam logic [18:0] C_FETCH_WAIT = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] C_FETCH_RDY  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0};
  localparam logic [18:0] C_DEC_B      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd1, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] C_DEC_J      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd1, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] C_ALUWB      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] C_MEMREAD    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] C_MEMWRITE   = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [18:0] C_MEMWB      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd1, 1'b0};
  localparam logic [18:0] C_TRAP       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1};

  // R-type (execr=1) or I-type ALU instruction through FETCH/DECODE/EXEC/ALUWB.
  task automatic run_alu(input string tag, input logic [31:0] ins, input logic execr,
                         input logic [2:0] exp_alu);
    instr = ins;
    run_cycle({tag, "_fetch"}, C_FETCH_RDY);
    run_cycle({tag, "_decode"}, C_DEC_B);
    if (execr)
      run_cycle({tag, "_execr"}, cv(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd0, exp_alu, 2'd0, 0));
    else
      run_cycle({tag, "_execi"}, cv(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, exp_alu, 2'd0, 0));
    run_cycle({tag, "_aluwb"}, C_ALUWB);
  endtask

  task automatic run_branch(input string tag, input logic [31:0] ins, input logic z,
                            input logic exp_pcw);
    instr = ins;
    Zero  = z;
    run_cycle({tag, "_fetch"}, C_FETCH_RDY);
    run_cycle({tag, "_decode"}, C_DEC_B);
    run_cycle({tag, "_branch"}, cv(0, 0, 0, 0, exp_pcw, 0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0, 0));
    Zero = 1'b0;
  endtask

  // Recover from TRAP with a one-cycle reset.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    run_cycle({tag, "_rst"}, C_ZERO);
    rst = 1'b0;
  endtask

  logic [2:0] f3_tab  [4] = '{3'b010, 3'b100, 3'b110, 3'b111};
  logic [2:0] alu_tab [4] = '{3'b101, 3'b100, 3'b011, 3'b010};

  initial begin
    rst      = 1'b1;
    MemReady = 1'b1;
    Zero     = 1'b0;
    instr    = 32'h0000_0000;
    @(posedge clk);
    #1;
    run_cycle("reset_outputs", C_ZERO);
    rst = 1'b0;

    // addi x1,x0,5 right after reset
    run_alu("addi", 32'h0050_0093, 1'b0, 3'b000);
    // I-type with bit30 set must still add
    run_alu("addi_neg", 32'hC000_0093, 1'b0, 3'b000);

    // lw x5,8(x1) with 3 FETCH and 2 MEMREAD wait cycles: 10 cycles total
    instr     = 32'h0080_A283;
    MemReady  = 1'b0;
    irw_count = 0;
    repeat (3) run_cycle("lw_fetch_wait", C_FETCH_WAIT);
    MemReady = 1'b1;
    run_cycle("lw_fetch", C_FETCH_RDY);
    MemReady = 1'b0;
    run_cycle("lw_decode", C_DEC_B);
    MemReady = 1'b1;
    run_cycle("lw_memadr", cv(0, 0, 1, 0, 0, 0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 0));
    MemReady = 1'b0;
    repeat (2) run_cycle("lw_memread_wait", C_MEMREAD);
    MemReady = 1'b1;
    run_cycle("lw_memread", C_MEMREAD);
    MemReady = 1'b0;
    run_cycle("lw_memwb", C_MEMWB);
    check("lw_irwrite_pulses", 32'(irw_count), 32'd1);
    MemReady = 1'b1;

    // sw x5,8(x1), zero-wait: 4 cycles then FETCH
    instr = 32'h0050_A423;
    run_cycle("sw_fetch", C_FETCH_RDY);
    run_cycle("sw_decode", C_DEC_B);
    run_cycle("sw_memadr", cv(0, 0, 1, 0, 0, 0, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0, 0));
    run_cycle("sw_memwrite", C_MEMWRITE);

    // beq/bne against both Zero values
    run_branch("beq_z1", 32'h0000_0463, 1'b1, 1'b1);
    run_branch("beq_z0", 32'h0000_0463, 1'b0, 1'b0);
    run_branch("bne_z1", 32'h0000_1463, 1'b1, 1'b0);
    run_branch("bne_z0", 32'h0000_1463, 1'b0, 1'b1);

    // sub vs add on the same R-type encoding
    run_alu("sub", 32'h4020_81B3, 1'b1, 3'b001);
    run_alu("add", 32'h0020_81B3, 1'b1, 3'b000);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] r_ins;
      r_ins = {7'b0000000, 5'd2, 5'd1, f3_tab[i], 5'd3, 7'b0110011};
      run_alu($sformatf("rtype_f3_%0d", f3_tab[i]), r_ins, 1'b1, alu_tab[i]);
    end

    // jal x1,8
    instr = 32'h0080_00EF;
    run_cycle("jal_fetch", C_FETCH_RDY);
    run_cycle("jal_decode", C_DEC_J);
    run_cycle("jal_jal", cv(0, 0, 0, 0, 1, 0, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0, 0));
    run_cycle("jal_aluwb", C_ALUWB);

    // lui x1,0x12345
    instr = 32'h1234_50B7;
    run_cycle("lui_fetch", C_FETCH_RDY);
    run_cycle("lui_decode", C_DEC_B);
    run_cycle("lui_lui", cv(0, 0, 0, 0, 0, 0, 3'd4, 2'd3, 2'd1, 3'd0, 2'd0, 0));
    run_cycle("lui_aluwb", C_ALUWB);

    // sll traps from DECODE and holds for 20 cycles regardless of MemReady
    instr = 32'h0020_9133;
    run_cycle("sll_fetch", C_FETCH_RDY);
    run_cycle("sll_decode", C_DEC_B);
    for (int i = 0; i < 20; i++) begin
      MemReady = i[0];
      run_cycle($sformatf("sll_trap_%0d", i), C_TRAP);
    end
    MemReady = 1'b1;
    pulse_reset("sll");
    run_cycle("sll_after_rst_fetch", C_FETCH_RDY);
    instr = 32'h0000_0000;
    run_cycle("bad_op_decode", C_DEC_B);
    run_cycle("bad_op_trap", C_TRAP);
    pulse_reset("bad_op");

    // blt is not supported
    instr = 32'h0000_4463;
    run_cycle("blt_fetch", C_FETCH_RDY);
    run_cycle("blt_decode", C_DEC_B);
    run_cycle("blt_trap", C_TRAP);
    pulse_reset("blt");

    // lb traps from MEMADR on funct3
    instr = 32'h0000_8283;
    run_cycle("lb_fetch", C_FETCH_RDY);
    run_cycle("lb_decode", C_DEC_B);
    run_cycle("lb_memadr", cv(0, 0, 1, 0, 0, 0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 0));
    run_cycle("lb_trap", C_TRAP);
    pulse_reset("lb");

    // reset asserted while a store is waiting on memory
    instr = 32'h0050_A423;
    run_cycle("swr_fetch", C_FETCH_RDY);
    run_cycle("swr_decode", C_DEC_B);
    MemReady = 1'b0;
    run_cycle("swr_memadr", cv(0, 0, 1, 0, 0, 0, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0, 0));
    run_cycle("swr_memwrite_wait", C_MEMWRITE);
    pulse_reset("swr");
    run_cycle("swr_after_rst_fetch", C_FETCH_WAIT);
    MemReady = 1'b1;
    run_cycle("swr_after_rst_fetch_rdy", C_FETCH_RDY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
